// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-wide RAM port arbiter: bus widths,
// transfer-length encodings, FSM state codes and requester identities.
package mem_arbiter_pkg;

    localparam int RegBus  = 32;
    localparam int AddrBus = 32;

    // mem_len carries bytes-1; the unused code 2 behaves as a word
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// MEM stage, serialising 1/2/4-byte transfers and assembling little-endian reads.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                if_req,
    input  logic [AddrBus-1:0]  if_addr,
    output logic                if_rdy,
    output logic [RegBus-1:0]   if_inst,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [1:0]          mem_len,
    input  logic [AddrBus-1:0]  mem_addr,
    input  logic [RegBus-1:0]   mem_wdata,
    output logic                mem_rdy,
    output logic [RegBus-1:0]   mem_rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   ram_a,
    output logic                ram_wr,
    output logic [7:0]          ram_dout,
    input  logic [7:0]          ram_din
);

    // Handshake: a requester holds req (and its fields) until its one-cycle rdy
    // pulse; fields are latched at grant and ignored afterwards.

    state_t              state_q, state_d;
    owner_t              owner_q;
    logic                we_q;
    logic [2:0]          cnt_q, nbytes_q, next_cnt;
    logic [ADDR_W-1:0]   addr_q, req_addr, next_a;
    logic [RegBus-1:0]   wdata_q, asm_q, inst_q, rdata_q;
    logic [1:0]          rd_idx, wr_idx;
    logic                grant_mem, grant_if, kill_if;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[AddrBus-1:ADDR_W], mem_addr[AddrBus-1:ADDR_W]};

    assign grant_mem = (state_q == IDLE) && mem_req;
    assign grant_if  = (state_q == IDLE) && !mem_req && if_req && !flush;
    assign kill_if   = flush && (owner_q == OWN_IF) && ((state_q == RD) || (state_q == DONE));
    assign req_addr  = grant_mem ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    assign next_cnt  = cnt_q + 3'd1;
    assign next_a    = addr_q + ADDR_W'(next_cnt);
    // In RD the byte arriving now was addressed one cycle earlier
    assign rd_idx    = cnt_q[1:0] - 2'd1;
    assign wr_idx    = next_cnt[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_mem)     state_d = mem_we ? WR : RD;
                else if (grant_if) state_d = RD;
            end
            RD: begin
                if (kill_if)                 state_d = IDLE;
                else if (cnt_q == nbytes_q)  state_d = DONE;
            end
            WR: begin
                if (next_cnt == nbytes_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        if_rdy    = (state_q == DONE) && (owner_q == OWN_IF) && !flush;
        mem_rdy   = (state_q == DONE) && (owner_q == OWN_MEM);
        if_inst   = if_rdy ? asm_q : inst_q;
        mem_rdata = (mem_rdy && !we_q) ? asm_q : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            nbytes_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            inst_q   <= '0;
            rdata_q  <= '0;
            ram_a    <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
        end else begin
            ram_wr <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_mem || grant_if) begin
                        owner_q  <= grant_mem ? OWN_MEM : OWN_IF;
                        we_q     <= grant_mem && mem_we;
                        nbytes_q <= grant_mem ? len_bytes(mem_len) : 3'd4;
                        cnt_q    <= '0;
                        asm_q    <= '0;
                        addr_q   <= req_addr;
                        ram_a    <= req_addr;
                        wdata_q  <= mem_wdata;
                        if (grant_mem && mem_we) begin
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                        end
                    end
                end
                RD: begin
                    cnt_q <= next_cnt;
                    if (cnt_q != 3'd0) asm_q[{rd_idx, 3'b000} +: 8] <= ram_din;
                    if (!kill_if && (next_cnt < nbytes_q)) ram_a <= next_a;
                end
                WR: begin
                    cnt_q <= next_cnt;
                    if (next_cnt < nbytes_q) begin
                        ram_wr   <= 1'b1;
                        ram_a    <= next_a;
                        ram_dout <= wdata_q[{wr_idx, 3'b000} +: 8];
                    end
                end
                DONE: begin
                    if (owner_q == OWN_IF) begin
                        if (!flush) inst_q <= asm_q;
                    end else if (!we_q) begin
                        rdata_q <= asm_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model answers one cycle after its
// address; each task walks a transfer cycle by cycle against hand-derived values.
module tb_mem_arbiter;

    logic        clk, rst, flush;
    logic        if_req, if_rdy;
    logic [31:0] if_addr, if_inst;
    logic        mem_req, mem_we, mem_rdy;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, ram_wr;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout, ram_din;

    logic [7:0]  ram_mem [0:131071];
    int          pass_cnt = 0;
    int          check_cnt = 0;

    mem_arbiter #(.ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .busy(busy), .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears the cycle after the address
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 0; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_len = 0; mem_addr = 0; mem_wdata = 0;
        repeat (3) next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({busy, if_rdy, mem_rdy, ram_wr} !== 4'b0000) $display("FAIL reset_ctrl got %b exp 0000", {busy, if_rdy, mem_rdy, ram_wr});
        else pass_cnt++;
        check_cnt++;
        if ({if_inst, mem_rdata, ram_a, ram_dout} !== '0) $display("FAIL reset_data got %h %h %h %h exp 0", if_inst, mem_rdata, ram_a, ram_dout);
        else pass_cnt++;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_if_read();
        ram_mem[16] = 8'h13; ram_mem[17] = 8'h12; ram_mem[18] = 8'h11; ram_mem[19] = 8'h10;
        for (int k = 0; k <= 7; k++) begin
            if (k == 0) begin if_req = 1; if_addr = 32'h10; end
            if (k == 6) if_req = 0;
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                check_cnt++;
                if (ram_a !== 17'h10 + 17'(k - 1)) $display("FAIL if_ram_a cyc %0d got %h exp %h", k, ram_a, 17'h10 + 17'(k - 1));
                else pass_cnt++;
            end
            check_cnt++;
            if (if_rdy !== (k == 6)) $display("FAIL if_rdy cyc %0d got %b exp %b", k, if_rdy, (k == 6));
            else pass_cnt++;
            if (k == 6 || k == 7) begin
                check_cnt++;
                if (if_inst !== 32'h10111213) $display("FAIL if_inst cyc %0d got %h exp 10111213", k, if_inst);
                else pass_cnt++;
            end
            check_cnt++;
            if (busy !== (k >= 1 && k <= 6)) $display("FAIL if_busy cyc %0d got %b exp %b", k, busy, (k >= 1 && k <= 6));
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_store();
        for (int k = 0; k <= 4; k++) begin
            if (k == 0) begin mem_req = 1; mem_we = 1; mem_len = 2'd1; mem_addr = 32'h20; mem_wdata = 32'h0000AABB; end
            if (k == 3) begin mem_req = 0; mem_we = 0; end
            @(negedge clk);
            check_cnt++;
            if (ram_wr !== (k == 1 || k == 2)) $display("FAIL st_ram_wr cyc %0d got %b exp %b", k, ram_wr, (k == 1 || k == 2));
            else pass_cnt++;
            if (k == 1 || k == 2) begin
                check_cnt++;
                if ({ram_a, ram_dout} !== {17'h1F + 17'(k), (k == 1) ? 8'hBB : 8'hAA})
                    $display("FAIL st_bus cyc %0d got %h/%h exp %h/%h", k, ram_a, ram_dout, 17'h1F + 17'(k), (k == 1) ? 8'hBB : 8'hAA);
                else pass_cnt++;
            end
            check_cnt++;
            if (mem_rdy !== (k == 3)) $display("FAIL st_rdy cyc %0d got %b exp %b", k, mem_rdy, (k == 3));
            else pass_cnt++;
            next_cycle();
        end
        check_cnt++;
        if ({ram_mem[33], ram_mem[32]} !== 16'hAABB) $display("FAIL st_ram_content got %h exp aabb", {ram_mem[33], ram_mem[32]});
        else pass_cnt++;
    endtask

    task automatic test_half_load();
        for (int k = 0; k <= 5; k++) begin
            if (k == 0) begin mem_req = 1; mem_we = 0; mem_len = 2'd1; mem_addr = 32'h20; end
            if (k == 4) mem_req = 0;
            @(negedge clk);
            check_cnt++;
            if (mem_rdy !== (k == 4)) $display("FAIL ldh_rdy cyc %0d got %b exp %b", k, mem_rdy, (k == 4));
            else pass_cnt++;
            if (k >= 4) begin
                check_cnt++;
                if (mem_rdata !== 32'h0000AABB) $display("FAIL ldh_rdata cyc %0d got %h exp 0000aabb", k, mem_rdata);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_priority();
        ram_mem[5] = 8'h80;
        ram_mem[48] = 8'hDD; ram_mem[49] = 8'hCC; ram_mem[50] = 8'hBB; ram_mem[51] = 8'hAA;
        for (int k = 0; k <= 11; k++) begin
            if (k == 0) begin
                if_req = 1; if_addr = 32'h30;
                mem_req = 1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h5;
            end
            if (k == 3) mem_req = 0;
            if (k == 10) if_req = 0;
            @(negedge clk);
            if (k == 1 || k == 5) begin
                check_cnt++;
                if (ram_a !== ((k == 1) ? 17'h5 : 17'h30)) $display("FAIL pri_ram_a cyc %0d got %h exp %h", k, ram_a, (k == 1) ? 17'h5 : 17'h30);
                else pass_cnt++;
            end
            check_cnt++;
            if ({mem_rdy, if_rdy} !== {(k == 3), (k == 10)}) $display("FAIL pri_rdy cyc %0d got %b exp %b", k, {mem_rdy, if_rdy}, {(k == 3), (k == 10)});
            else pass_cnt++;
            if (k == 3) begin
                check_cnt++;
                if (mem_rdata !== 32'h00000080) $display("FAIL pri_rdata got %h exp 00000080", mem_rdata);
                else pass_cnt++;
            end
            if (k == 4) begin
                check_cnt++;
                if ({busy, if_inst} !== {1'b0, 32'h10111213}) $display("FAIL pri_gap got %b/%h exp 0/10111213", busy, if_inst);
                else pass_cnt++;
            end
            if (k == 10) begin
                check_cnt++;
                if (if_inst !== 32'hAABBCCDD) $display("FAIL pri_inst got %h exp aabbccdd", if_inst);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        ram_mem[6] = 8'h5A;
        for (int k = 0; k <= 9; k++) begin
            if (k == 0) begin if_req = 1; if_addr = 32'h10; end
            if (k == 1) begin mem_req = 1; mem_we = 0; mem_len = 2'd0; mem_addr = 32'h6; end
            if (k == 3) begin flush = 1; if_req = 0; end
            if (k == 4) flush = 0;
            if (k == 7) mem_req = 0;
            @(negedge clk);
            check_cnt++;
            if (if_rdy !== 1'b0) $display("FAIL fl_if_rdy cyc %0d got %b exp 0", k, if_rdy);
            else pass_cnt++;
            if (k == 4 || k == 5) begin
                check_cnt++;
                if (busy !== (k == 5)) $display("FAIL fl_busy cyc %0d got %b exp %b", k, busy, (k == 5));
                else pass_cnt++;
            end
            if (k == 5) begin
                check_cnt++;
                if (ram_a !== 17'h6) $display("FAIL fl_ram_a got %h exp 00006", ram_a);
                else pass_cnt++;
            end
            check_cnt++;
            if (mem_rdy !== (k == 7)) $display("FAIL fl_mem_rdy cyc %0d got %b exp %b", k, mem_rdy, (k == 7));
            else pass_cnt++;
            if (k == 7) begin
                check_cnt++;
                if ({mem_rdata, if_inst} !== {32'h0000005A, 32'hAABBCCDD}) $display("FAIL fl_data got %h/%h exp 0000005a/aabbccdd", mem_rdata, if_inst);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        ram_mem[131071] = 8'hEF; ram_mem[0] = 8'hBE; ram_mem[1] = 8'hAD; ram_mem[2] = 8'hDE;
        for (int k = 0; k <= 7; k++) begin
            if (k == 0) begin if_req = 1; if_addr = 32'h0001FFFF; end
            if (k == 6) if_req = 0;
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                check_cnt++;
                if (ram_a !== 17'h1FFFF + 17'(k - 1)) $display("FAIL wrap_ram_a cyc %0d got %h exp %h", k, ram_a, 17'h1FFFF + 17'(k - 1));
                else pass_cnt++;
            end
            if (k == 6) begin
                check_cnt++;
                if ({if_rdy, if_inst} !== {1'b1, 32'hDEADBEEF}) $display("FAIL wrap_inst got %b/%h exp 1/deadbeef", if_rdy, if_inst);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_store();
        for (int k = 0; k <= 8; k++) begin
            if (k == 0) begin mem_req = 1; mem_we = 1; mem_len = 2'd3; mem_addr = 32'h40; mem_wdata = 32'h11223344; end
            if (k == 2) rst = 1;
            if (k == 3) begin rst = 0; mem_req = 0; mem_we = 0; end
            @(negedge clk);
            if (k == 1) begin
                check_cnt++;
                if ({ram_wr, ram_a, ram_dout} !== {1'b1, 17'h40, 8'h44}) $display("FAIL rs_pre got %b/%h/%h exp 1/00040/44", ram_wr, ram_a, ram_dout);
                else pass_cnt++;
            end
            if (k >= 2) begin
                check_cnt++;
                if ({ram_wr, busy, mem_rdy} !== 3'b000) $display("FAIL rs_quiet cyc %0d got %b exp 000", k, {ram_wr, busy, mem_rdy});
                else pass_cnt++;
            end
            if (k == 4) begin
                check_cnt++;
                if ({if_inst, mem_rdata} !== 64'h0) $display("FAIL rs_data got %h/%h exp 0/0", if_inst, mem_rdata);
                else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_store();
        test_half_load();
        test_priority();
        test_flush();
        test_wrap();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
